// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converters.
//   BCD_DIGIT_W    : bits per BCD digit
//   bcd_state_t    : converter control states (IDLE / CONVERT / DONE)
//   bcd_digits_for : minimum digit count that holds every value of a given binary width
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } bcd_state_t;

    // Count the decimal digits of the largest unsigned value of 'width' bits.
    function automatic int bcd_digits_for(input int width);
        longint unsigned max_v;
        int              n;
        max_v = (64'd1 << width) - 64'd1;
        n     = 0;
        while (max_v != 64'd0) begin
            max_v = max_v / 64'd10;
            n     = n + 1;
        end
        if (n == 0) begin
            n = 1;
        end else begin
            n = n;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: every BCD digit that is above 4 gets 3 added,
// then the whole {bcd, binary} scratch word shifts left by one bit.
// Ports:
//   scratch      : current {bcd digits, remaining binary bits}
//   scratch_next : scratch after adjust-and-shift
//   shift_out    : bit shifted out of the top BCD digit (decimal carry past the last digit)
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic [BCD_DIGIT_W*DIGITS+BIN_W-1:0] scratch,
    output logic [BCD_DIGIT_W*DIGITS+BIN_W-1:0] scratch_next,
    output logic                                shift_out
);

    localparam int SCR_W = BCD_DIGIT_W * DIGITS + BIN_W;

    logic [SCR_W-1:0] adj_s;

    // Parallel add-3 on every digit, then the one-bit left shift.
    always_comb begin
        adj_s = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[BIN_W + BCD_DIGIT_W*d +: BCD_DIGIT_W] > 4'd4) begin
                adj_s[BIN_W + BCD_DIGIT_W*d +: BCD_DIGIT_W] =
                    scratch[BIN_W + BCD_DIGIT_W*d +: BCD_DIGIT_W] + 4'd3;
            end else begin
                adj_s[BIN_W + BCD_DIGIT_W*d +: BCD_DIGIT_W] =
                    scratch[BIN_W + BCD_DIGIT_W*d +: BCD_DIGIT_W];
            end
        end
        shift_out    = adj_s[SCR_W-1];
        scratch_next = {adj_s[SCR_W-2:0], 1'b0};
    end

endmodule

// File: rtl/bin2bcd_param.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3), one iteration per clock.
// Ports:
//   clk       : rising-edge clock
//   reset     : synchronous active-low reset
//   en        : start request, honoured only when idle
//   is_signed : treat bin as two's complement (sampled with en)
//   bin       : binary operand (sampled with en)
//   bcd_out   : result digits, digit 0 (ones) in bits [3:0]
//   sign      : result was negative (signed mode only)
//   ovf       : magnitude exceeded DIGITS digits; bcd_out is the value modulo 10^DIGITS
//   busy      : conversion in progress
//   rdy       : one-cycle pulse when bcd_out/sign/ovf have just been updated
module bin2bcd_param
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          is_signed,
    input  logic [BIN_W-1:0]              bin,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          sign,
    output logic                          ovf,
    output logic                          busy,
    output logic                          rdy
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int SCR_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    bcd_state_t       state_r;
    bcd_state_t       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [SCR_W-1:0] scratch_r;
    logic [SCR_W-1:0] step_next_s;
    logic             step_out_s;
    logic             sign_pend_r;
    logic             ovf_pend_r;
    logic             neg_s;
    logic [BIN_W-1:0] mag_s;

    bcd_dabble_step #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_step (
        .scratch      (scratch_r),
        .scratch_next (step_next_s),
        .shift_out    (step_out_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: the last iteration is the one that sees cnt_r == BIN_W-1.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (en) begin
                    state_nxt_s = CONVERT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CONVERT: begin
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CONVERT;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand magnitude; the most negative value negates to itself, which is
    // the correct unsigned magnitude 2^(BIN_W-1).
    always_comb begin
        neg_s = is_signed & bin[BIN_W-1];
        if (neg_s) begin
            mag_s = ~bin + {{(BIN_W-1){1'b0}}, 1'b1};
        end else begin
            mag_s = bin;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r       <= '0;
            scratch_r   <= '0;
            sign_pend_r <= 1'b0;
            ovf_pend_r  <= 1'b0;
            bcd_out     <= '0;
            sign        <= 1'b0;
            ovf         <= 1'b0;
            busy        <= 1'b0;
            rdy         <= 1'b0;
        end else begin
            rdy <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (en) begin
                        scratch_r   <= {{BCD_W{1'b0}}, mag_s};
                        sign_pend_r <= neg_s;
                        ovf_pend_r  <= 1'b0;
                        cnt_r       <= '0;
                        busy        <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                CONVERT: begin
                    scratch_r  <= step_next_s;
                    ovf_pend_r <= ovf_pend_r | step_out_s;
                    cnt_r      <= cnt_r + CNT_W'(1);
                end
                DONE: begin
                    bcd_out <= scratch_r[SCR_W-1 -: BCD_W];
                    sign    <= sign_pend_r;
                    ovf     <= ovf_pend_r;
                    rdy     <= 1'b1;
                    busy    <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_param.sv
module tb_bin2bcd_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_v        [3];
    logic        is_signed_v [3];
    logic [15:0] bin_v       [3];
    logic        sign_v      [3];
    logic        ovf_v       [3];
    logic        busy_v      [3];
    logic        rdy_v       [3];
    logic [19:0] bcd0;
    logic [15:0] bcd1;
    logic [11:0] bcd2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bin2bcd_param #(.BIN_W(16), .DIGITS(5)) dut0 (
        .clk(clk), .reset(reset), .en(en_v[0]), .is_signed(is_signed_v[0]), .bin(bin_v[0]),
        .bcd_out(bcd0), .sign(sign_v[0]), .ovf(ovf_v[0]), .busy(busy_v[0]), .rdy(rdy_v[0]));

    bin2bcd_param #(.BIN_W(16), .DIGITS(4)) dut1 (
        .clk(clk), .reset(reset), .en(en_v[1]), .is_signed(is_signed_v[1]), .bin(bin_v[1]),
        .bcd_out(bcd1), .sign(sign_v[1]), .ovf(ovf_v[1]), .busy(busy_v[1]), .rdy(rdy_v[1]));

    bin2bcd_param #(.BIN_W(8), .DIGITS(3)) dut2 (
        .clk(clk), .reset(reset), .en(en_v[2]), .is_signed(is_signed_v[2]), .bin(bin_v[2][7:0]),
        .bcd_out(bcd2), .sign(sign_v[2]), .ovf(ovf_v[2]), .busy(busy_v[2]), .rdy(rdy_v[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Start one conversion on DUT 'which'; edges = edges after acceptance until rdy (-1 on timeout).
    task automatic convert(input int which, input logic [15:0] b, input logic s,
                           output int edges, output logic busy_seen, output logic rdy_after);
        @(negedge clk);
        en_v[which]        = 1'b1;
        bin_v[which]       = b;
        is_signed_v[which] = s;
        @(posedge clk); #1;
        en_v[which] = 1'b0;
        busy_seen   = busy_v[which];
        edges       = -1;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            if (rdy_v[which]) begin
                edges = k;
                break;
            end
        end
        @(posedge clk); #1;
        rdy_after = rdy_v[which];
    endtask

    int          e;
    logic        bs;
    logic        ra;
    int          r1;
    int          r2;
    int          nrdy;
    logic [19:0] v1;
    logic [19:0] v2;

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en_v[i] = 1'b0; is_signed_v[i] = 1'b0; bin_v[i] = 16'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_bcd",  32'(bcd0), 32'h0);
        check("rst_sign", 32'(sign_v[0]), 32'd0);
        check("rst_ovf",  32'(ovf_v[0]), 32'd0);
        check("rst_busy", 32'(busy_v[0]), 32'd0);
        check("rst_rdy",  32'(rdy_v[0]), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Unsigned full scale
        convert(0, 16'd65535, 1'b0, e, bs, ra);
        check("u65535_busy", 32'(bs), 32'd1);
        check("u65535_lat",  32'(e), 32'd17);
        check("u65535_bcd",  32'(bcd0), 32'h65535);
        check("u65535_sign", 32'(sign_v[0]), 32'd0);
        check("u65535_ovf",  32'(ovf_v[0]), 32'd0);
        check("u65535_rdy_pulse", 32'(ra), 32'd0);
        check("u65535_hold", 32'(bcd0), 32'h65535);

        // Signed cases
        convert(0, 16'hFFFF, 1'b1, e, bs, ra);
        check("s_m1_bcd",  32'(bcd0), 32'h00001);
        check("s_m1_sign", 32'(sign_v[0]), 32'd1);
        convert(0, 16'h8000, 1'b1, e, bs, ra);
        check("s_min_bcd",  32'(bcd0), 32'h32768);
        check("s_min_sign", 32'(sign_v[0]), 32'd1);
        check("s_min_ovf",  32'(ovf_v[0]), 32'd0);
        convert(0, 16'h0000, 1'b1, e, bs, ra);
        check("zero_lat",  32'(e), 32'd17);
        check("zero_bcd",  32'(bcd0), 32'h0);
        check("zero_sign", 32'(sign_v[0]), 32'd0);
        check("zero_ovf",  32'(ovf_v[0]), 32'd0);

        // Four-digit overflow
        convert(1, 16'd12345, 1'b0, e, bs, ra);
        check("d4_12345_bcd", 32'(bcd1), 32'h2345);
        check("d4_12345_ovf", 32'(ovf_v[1]), 32'd1);
        convert(1, 16'd9999, 1'b0, e, bs, ra);
        check("d4_9999_bcd", 32'(bcd1), 32'h9999);
        check("d4_9999_ovf", 32'(ovf_v[1]), 32'd0);

        // en held high with bin changing every cycle
        @(negedge clk);
        en_v[0] = 1'b1; bin_v[0] = 16'd100; is_signed_v[0] = 1'b0;
        r1 = -1; r2 = -1; v1 = '0; v2 = '0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (rdy_v[0]) begin
                if (r1 < 0) begin
                    r1 = k; v1 = bcd0;
                end else begin
                    r2 = k; v2 = bcd0; en_v[0] = 1'b0;
                    break;
                end
            end
            bin_v[0] = 16'(1000 + k);
        end
        en_v[0] = 1'b0;
        check("hold_r1",  32'(r1), 32'd17);
        check("hold_v1",  32'(v1), 32'h00100);
        check("hold_r2",  32'(r2), 32'd35);
        check("hold_v2",  32'(v2), 32'h01017);
        check("hold_per", 32'(r2 - r1), 32'd18);
        repeat (2) @(posedge clk);
        #1;
        check("hold_idle", 32'(busy_v[0]), 32'd0);

        // Reset at iteration 8
        @(negedge clk);
        en_v[0] = 1'b1; bin_v[0] = 16'd4321;
        @(posedge clk); #1;
        en_v[0] = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_bcd",  32'(bcd0), 32'h0);
        check("abort_busy", 32'(busy_v[0]), 32'd0);
        check("abort_rdy",  32'(rdy_v[0]), 32'd0);
        check("abort_sign", 32'(sign_v[0]), 32'd0);
        reset = 1'b1;
        nrdy = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (rdy_v[0]) nrdy++;
        end
        check("abort_no_rdy", 32'(nrdy), 32'd0);
        convert(0, 16'd1000, 1'b0, e, bs, ra);
        check("after_abort_bcd", 32'(bcd0), 32'h01000);
        check("after_abort_lat", 32'(e), 32'd17);

        // 8-bit, 3-digit instance
        convert(2, 16'd255, 1'b0, e, bs, ra);
        check("w8_255_lat", 32'(e), 32'd9);
        check("w8_255_bcd", 32'(bcd2), 32'h255);
        check("w8_255_ovf", 32'(ovf_v[2]), 32'd0);
        convert(2, 16'h0080, 1'b1, e, bs, ra);
        check("w8_m128_bcd",  32'(bcd2), 32'h128);
        check("w8_m128_sign", 32'(sign_v[2]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin2bcd_param.md
Name: bin2bcd_param

Overview:
Parametrised, multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble). It replaces the fixed 16-bit, 4-digit converter in the display/readout path of the matrix multiplier. It adds generic input width and digit count, a run-time signed mode with a sign output, an overflow flag, and a busy indication. It performs one add-3-then-shift iteration per clock, so latency is roughly half that of the previous two-phase design.

Parameters:
BIN_W, 16, width of binary input; legal range 4..32.
DIGITS, 5, number of BCD digits produced; must be >= 1; full range needs ceil(BIN_W*log10(2)) digits.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk)
en  input  1  start request; sampled only in IDLE
is_signed  input  1  treat bin as two's complement; sampled with en
bin  input  BIN_W  binary operand; sampled with en
bcd_out  output  4*DIGITS  result digits; digit 0 = bits [3:0] = ones
sign  output  1  1 = result negative (signed mode only)
ovf  output  1  1 = magnitude did not fit in DIGITS digits
busy  output  1  high while a conversion is in progress
rdy  output  1  one-cycle pulse: bcd_out/sign/ovf just updated

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE, iteration counter=0, scratch=0; bcd_out=0, sign=0, ovf=0, busy=0, rdy=0. Reset dominates every other input.
- Reset mid-conversion aborts the conversion. No rdy is produced, and outputs go to their reset values.
- States: IDLE, CONVERT, DONE.
- IDLE, edge with en=1:
  - Capture magnitude: if is_signed=1 and bin[BIN_W-1]=1, magnitude = (~bin)+1 (BIN_W-bit unsigned) and sign_pending=1; otherwise magnitude = bin and sign_pending=0.
  - Clear BCD scratch and ovf_pending; counter=0; busy<=1; go to CONVERT.
- IDLE with en=0: hold. Outputs keep the last result indefinitely.
- CONVERT, each edge (one iteration):
  - For every digit, if its value > 4, add 3 (all digits in parallel, combinational).
  - Shift {bcd_scratch, magnitude} left by 1.
  - The bit shifted out of the top digit ORs into ovf_pending.
  - counter++; after iteration BIN_W (counter reaches BIN_W-1 at this edge) go to DONE.
- DONE, one edge: bcd_out<=scratch, sign<=sign_pending, ovf<=ovf_pending, rdy<=1, busy<=0, go to IDLE.
- rdy is high only in the cycle after the DONE edge; it is cleared on the next edge.
- Latency:
  - en sampled at edge E0; iterations at E1..E_BIN_W; results and rdy visible after edge E_(BIN_W+1).
  - Total BIN_W+1 edges from acceptance to rdy; rdy is high during the cycle following E_(BIN_W+1).
  - Back-to-back: en may be accepted at E_(BIN_W+2) (the rdy cycle is IDLE). Max throughput is one conversion per BIN_W+2 cycles.
- en while busy (CONVERT/DONE) is ignored, not queued. bin and is_signed may change freely while busy.
- Boundary cases:
  - Zero input gives all-zero digits, sign=0, ovf=0, with normal latency.
  - Signed most-negative input -2^(BIN_W-1) gives magnitude 2^(BIN_W-1) (fits unsigned BIN_W), sign=1.
  - Negative zero cannot occur.
- ovf=1: bcd_out holds the low DIGITS digits of the true value (modulo 10^DIGITS).
- Widths: counter is ceil(log2(BIN_W+1)) bits; scratch is 4*DIGITS+BIN_W bits. No arithmetic wraps except the intended modulo on overflow.

Decomposition:
- Shared package bcd_pkg holds:
  - constant BCD_DIGIT_W=4;
  - state typedef (IDLE/CONVERT/DONE);
  - function bcd_digits_for(width), returning the minimum DIGITS for a width.
- Sub-module bcd_dabble_step (combinational, parameters BIN_W/DIGITS): inputs scratch; outputs next scratch and shifted-out bit. It is instantiated once and reused by other converters.

Test Plan:
- Defaults, is_signed=0, bin=16'd65535, en pulse -> busy next cycle; rdy pulse exactly 17 edges after accept; bcd_out=20'h65535, sign=0, ovf=0.
- is_signed=1, bin=16'hFFFF -> bcd_out=20'h00001, sign=1; then bin=16'h8000 signed -> 20'h32768, sign=1; bin=0 -> 20'h00000, sign=0, rdy still pulses.
- DIGITS=4, bin=16'd12345 unsigned -> ovf=1, bcd_out=16'h2345; then bin=16'd9999 -> ovf=0, bcd_out=16'h9999.
- en held high continuously with changing bin -> en ignored while busy; result matches bin at accept edge; next accept on the rdy cycle; period 18 cycles.
- reset=0 for one edge at iteration 8 -> no rdy, all outputs 0, state IDLE; new en then converts bin=16'd1000 -> 20'h01000.
- BIN_W=8, DIGITS=3: bin=8'd255 unsigned -> 12'h255 after 9 edges; bin=8'h80 signed -> 12'h128, sign=1.
